// File: rtl/axi_bus_reg_slice.sv
// AXI4 register slice: every channel (AW, W, AR forward; B, R reverse) goes through its own 2-entry skid buffer.
// Latency: 1 clk per channel when not stalled; full throughput of 1 beat/clk.
// Backpressure: input ready is registered (skid stage empty) and never depends combinationally on downstream ready.

module axi_bus_reg_slice_skid #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic [W-1:0] in_dat_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_dat_o
);
    logic         out_vld_q, out_vld_d;
    logic [W-1:0] out_dat_q, out_dat_d;
    logic         skd_vld_q, skd_vld_d;
    logic [W-1:0] skd_dat_q, skd_dat_d;
    logic         in_rdy_q, in_rdy_d;
    logic         in_acc, out_acc;

    assign in_acc    = in_vld_i && in_rdy_q;
    assign out_acc   = out_vld_q && out_rdy_i;
    assign in_rdy_o  = in_rdy_q;
    assign out_vld_o = out_vld_q;
    assign out_dat_o = out_dat_q;

    always_comb begin
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        skd_vld_d = skd_vld_q;
        skd_dat_d = skd_dat_q;
        if (skd_vld_q) begin
            // Input is closed while the skid is occupied; only a drain can make progress.
            if (out_acc) begin
                out_dat_d = skd_dat_q;
                skd_vld_d = 1'b0;
            end
        end else if (!out_vld_q || out_acc) begin
            out_vld_d = in_acc;
            if (in_acc) begin
                out_dat_d = in_dat_i;
            end
        end else if (in_acc) begin
            skd_vld_d = 1'b1;
            skd_dat_d = in_dat_i;
        end
        in_rdy_d = !skd_vld_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            skd_vld_q <= 1'b0;
            skd_dat_q <= '0;
            in_rdy_q  <= 1'b0;
        end else begin
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            skd_vld_q <= skd_vld_d;
            skd_dat_q <= skd_dat_d;
            in_rdy_q  <= in_rdy_d;
        end
    end
endmodule

module axi_bus_reg_slice #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 6,
    parameter int unsigned AXI_USER_WIDTH = 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    // AW slave side
    input  logic [AXI_ID_WIDTH-1:0]     s_aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_aw_addr,
    input  logic [7:0]                  s_aw_len,
    input  logic [2:0]                  s_aw_size,
    input  logic [1:0]                  s_aw_burst,
    input  logic                        s_aw_lock,
    input  logic [3:0]                  s_aw_cache,
    input  logic [2:0]                  s_aw_prot,
    input  logic [3:0]                  s_aw_region,
    input  logic [3:0]                  s_aw_qos,
    input  logic [5:0]                  s_aw_atop,
    input  logic [AXI_USER_WIDTH-1:0]   s_aw_user,
    input  logic                        s_aw_valid,
    output logic                        s_aw_ready,
    // W slave side
    input  logic [AXI_DATA_WIDTH-1:0]   s_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_w_strb,
    input  logic                        s_w_last,
    input  logic [AXI_USER_WIDTH-1:0]   s_w_user,
    input  logic                        s_w_valid,
    output logic                        s_w_ready,
    // B slave side
    output logic [AXI_ID_WIDTH-1:0]     s_b_id,
    output logic [1:0]                  s_b_resp,
    output logic [AXI_USER_WIDTH-1:0]   s_b_user,
    output logic                        s_b_valid,
    input  logic                        s_b_ready,
    // AR slave side
    input  logic [AXI_ID_WIDTH-1:0]     s_ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_ar_addr,
    input  logic [7:0]                  s_ar_len,
    input  logic [2:0]                  s_ar_size,
    input  logic [1:0]                  s_ar_burst,
    input  logic                        s_ar_lock,
    input  logic [3:0]                  s_ar_cache,
    input  logic [2:0]                  s_ar_prot,
    input  logic [3:0]                  s_ar_region,
    input  logic [3:0]                  s_ar_qos,
    input  logic [AXI_USER_WIDTH-1:0]   s_ar_user,
    input  logic                        s_ar_valid,
    output logic                        s_ar_ready,
    // R slave side
    output logic [AXI_ID_WIDTH-1:0]     s_r_id,
    output logic [AXI_DATA_WIDTH-1:0]   s_r_data,
    output logic [1:0]                  s_r_resp,
    output logic                        s_r_last,
    output logic [AXI_USER_WIDTH-1:0]   s_r_user,
    output logic                        s_r_valid,
    input  logic                        s_r_ready,
    // AW master side
    output logic [AXI_ID_WIDTH-1:0]     m_aw_id,
    output logic [AXI_ADDR_WIDTH-1:0]   m_aw_addr,
    output logic [7:0]                  m_aw_len,
    output logic [2:0]                  m_aw_size,
    output logic [1:0]                  m_aw_burst,
    output logic                        m_aw_lock,
    output logic [3:0]                  m_aw_cache,
    output logic [2:0]                  m_aw_prot,
    output logic [3:0]                  m_aw_region,
    output logic [3:0]                  m_aw_qos,
    output logic [5:0]                  m_aw_atop,
    output logic [AXI_USER_WIDTH-1:0]   m_aw_user,
    output logic                        m_aw_valid,
    input  logic                        m_aw_ready,
    // W master side
    output logic [AXI_DATA_WIDTH-1:0]   m_w_data,
    output logic [AXI_DATA_WIDTH/8-1:0] m_w_strb,
    output logic                        m_w_last,
    output logic [AXI_USER_WIDTH-1:0]   m_w_user,
    output logic                        m_w_valid,
    input  logic                        m_w_ready,
    // B master side
    input  logic [AXI_ID_WIDTH-1:0]     m_b_id,
    input  logic [1:0]                  m_b_resp,
    input  logic [AXI_USER_WIDTH-1:0]   m_b_user,
    input  logic                        m_b_valid,
    output logic                        m_b_ready,
    // AR master side
    output logic [AXI_ID_WIDTH-1:0]     m_ar_id,
    output logic [AXI_ADDR_WIDTH-1:0]   m_ar_addr,
    output logic [7:0]                  m_ar_len,
    output logic [2:0]                  m_ar_size,
    output logic [1:0]                  m_ar_burst,
    output logic                        m_ar_lock,
    output logic [3:0]                  m_ar_cache,
    output logic [2:0]                  m_ar_prot,
    output logic [3:0]                  m_ar_region,
    output logic [3:0]                  m_ar_qos,
    output logic [AXI_USER_WIDTH-1:0]   m_ar_user,
    output logic                        m_ar_valid,
    input  logic                        m_ar_ready,
    // R master side
    input  logic [AXI_ID_WIDTH-1:0]     m_r_id,
    input  logic [AXI_DATA_WIDTH-1:0]   m_r_data,
    input  logic [1:0]                  m_r_resp,
    input  logic                        m_r_last,
    input  logic [AXI_USER_WIDTH-1:0]   m_r_user,
    input  logic                        m_r_valid,
    output logic                        m_r_ready
);
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam int unsigned AR_W   = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4
                                   + AXI_USER_WIDTH;
    localparam int unsigned AW_W   = AR_W + 6;
    localparam int unsigned W_W    = AXI_DATA_WIDTH + STRB_W + 1 + AXI_USER_WIDTH;
    localparam int unsigned B_W    = AXI_ID_WIDTH + 2 + AXI_USER_WIDTH;
    localparam int unsigned R_W    = AXI_ID_WIDTH + AXI_DATA_WIDTH + 2 + 1 + AXI_USER_WIDTH;

    logic [AW_W-1:0] aw_in_dat, aw_out_dat;
    logic [W_W-1:0]  w_in_dat,  w_out_dat;
    logic [B_W-1:0]  b_in_dat,  b_out_dat;
    logic [AR_W-1:0] ar_in_dat, ar_out_dat;
    logic [R_W-1:0]  r_in_dat,  r_out_dat;

    // Channels are flattened into one vector each so a single skid implementation serves all five.
    assign aw_in_dat = {s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_lock,
                        s_aw_cache, s_aw_prot, s_aw_region, s_aw_qos, s_aw_atop, s_aw_user};
    assign {m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_lock,
            m_aw_cache, m_aw_prot, m_aw_region, m_aw_qos, m_aw_atop, m_aw_user} = aw_out_dat;

    assign w_in_dat = {s_w_data, s_w_strb, s_w_last, s_w_user};
    assign {m_w_data, m_w_strb, m_w_last, m_w_user} = w_out_dat;

    assign b_in_dat = {m_b_id, m_b_resp, m_b_user};
    assign {s_b_id, s_b_resp, s_b_user} = b_out_dat;

    assign ar_in_dat = {s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_lock,
                        s_ar_cache, s_ar_prot, s_ar_region, s_ar_qos, s_ar_user};
    assign {m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_lock,
            m_ar_cache, m_ar_prot, m_ar_region, m_ar_qos, m_ar_user} = ar_out_dat;

    assign r_in_dat = {m_r_id, m_r_data, m_r_resp, m_r_last, m_r_user};
    assign {s_r_id, s_r_data, s_r_resp, s_r_last, s_r_user} = r_out_dat;

    axi_bus_reg_slice_skid #(.W(AW_W)) u_aw (
        .clk(clk), .rstn(rstn),
        .in_vld_i(s_aw_valid), .in_rdy_o(s_aw_ready), .in_dat_i(aw_in_dat),
        .out_vld_o(m_aw_valid), .out_rdy_i(m_aw_ready), .out_dat_o(aw_out_dat)
    );

    axi_bus_reg_slice_skid #(.W(W_W)) u_w (
        .clk(clk), .rstn(rstn),
        .in_vld_i(s_w_valid), .in_rdy_o(s_w_ready), .in_dat_i(w_in_dat),
        .out_vld_o(m_w_valid), .out_rdy_i(m_w_ready), .out_dat_o(w_out_dat)
    );

    axi_bus_reg_slice_skid #(.W(B_W)) u_b (
        .clk(clk), .rstn(rstn),
        .in_vld_i(m_b_valid), .in_rdy_o(m_b_ready), .in_dat_i(b_in_dat),
        .out_vld_o(s_b_valid), .out_rdy_i(s_b_ready), .out_dat_o(b_out_dat)
    );

    axi_bus_reg_slice_skid #(.W(AR_W)) u_ar (
        .clk(clk), .rstn(rstn),
        .in_vld_i(s_ar_valid), .in_rdy_o(s_ar_ready), .in_dat_i(ar_in_dat),
        .out_vld_o(m_ar_valid), .out_rdy_i(m_ar_ready), .out_dat_o(ar_out_dat)
    );

    axi_bus_reg_slice_skid #(.W(R_W)) u_r (
        .clk(clk), .rstn(rstn),
        .in_vld_i(m_r_valid), .in_rdy_o(m_r_ready), .in_dat_i(r_in_dat),
        .out_vld_o(s_r_valid), .out_rdy_i(s_r_ready), .out_dat_o(r_out_dat)
    );
endmodule

// File: tb/tb_axi_bus_reg_slice.sv
// Directed bench for axi_bus_reg_slice: reset, single write, R backpressure, 256-beat read, random-ready scoreboard.
module tb_axi_bus_reg_slice;
    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic [5:0]  s_aw_id, m_aw_id, s_ar_id, m_ar_id, s_b_id, m_b_id, s_r_id, m_r_id;
    logic [31:0] s_aw_addr, m_aw_addr, s_ar_addr, m_ar_addr;
    logic [7:0]  s_aw_len, m_aw_len, s_ar_len, m_ar_len;
    logic [2:0]  s_aw_size, m_aw_size, s_ar_size, m_ar_size, s_aw_prot, m_aw_prot, s_ar_prot, m_ar_prot;
    logic [1:0]  s_aw_burst, m_aw_burst, s_ar_burst, m_ar_burst;
    logic        s_aw_lock, m_aw_lock, s_ar_lock, m_ar_lock;
    logic [3:0]  s_aw_cache, m_aw_cache, s_ar_cache, m_ar_cache, s_aw_region, m_aw_region;
    logic [3:0]  s_ar_region, m_ar_region, s_aw_qos, m_aw_qos, s_ar_qos, m_ar_qos;
    logic [5:0]  s_aw_atop, m_aw_atop;
    logic [0:0]  s_aw_user, m_aw_user, s_ar_user, m_ar_user, s_w_user, m_w_user;
    logic [0:0]  s_b_user, m_b_user, s_r_user, m_r_user;
    logic [63:0] s_w_data, m_w_data, s_r_data, m_r_data;
    logic [7:0]  s_w_strb, m_w_strb;
    logic        s_w_last, m_w_last, s_r_last, m_r_last;
    logic [1:0]  s_b_resp, m_b_resp, s_r_resp, m_r_resp;
    logic s_aw_valid, s_aw_ready, m_aw_valid, m_aw_ready;
    logic s_w_valid, s_w_ready, m_w_valid, m_w_ready;
    logic s_b_valid, s_b_ready, m_b_valid, m_b_ready;
    logic s_ar_valid, s_ar_ready, m_ar_valid, m_ar_ready;
    logic s_r_valid, s_r_ready, m_r_valid, m_r_ready;

    axi_bus_reg_slice dut (
        .clk(clk), .rstn(rstn),
        .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len), .s_aw_size(s_aw_size),
        .s_aw_burst(s_aw_burst), .s_aw_lock(s_aw_lock), .s_aw_cache(s_aw_cache), .s_aw_prot(s_aw_prot),
        .s_aw_region(s_aw_region), .s_aw_qos(s_aw_qos), .s_aw_atop(s_aw_atop), .s_aw_user(s_aw_user),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
        .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last), .s_w_user(s_w_user),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
        .s_b_id(s_b_id), .s_b_resp(s_b_resp), .s_b_user(s_b_user), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
        .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
        .s_ar_burst(s_ar_burst), .s_ar_lock(s_ar_lock), .s_ar_cache(s_ar_cache), .s_ar_prot(s_ar_prot),
        .s_ar_region(s_ar_region), .s_ar_qos(s_ar_qos), .s_ar_user(s_ar_user),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
        .s_r_id(s_r_id), .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last), .s_r_user(s_r_user),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
        .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len), .m_aw_size(m_aw_size),
        .m_aw_burst(m_aw_burst), .m_aw_lock(m_aw_lock), .m_aw_cache(m_aw_cache), .m_aw_prot(m_aw_prot),
        .m_aw_region(m_aw_region), .m_aw_qos(m_aw_qos), .m_aw_atop(m_aw_atop), .m_aw_user(m_aw_user),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
        .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last), .m_w_user(m_w_user),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
        .m_b_id(m_b_id), .m_b_resp(m_b_resp), .m_b_user(m_b_user), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
        .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
        .m_ar_burst(m_ar_burst), .m_ar_lock(m_ar_lock), .m_ar_cache(m_ar_cache), .m_ar_prot(m_ar_prot),
        .m_ar_region(m_ar_region), .m_ar_qos(m_ar_qos), .m_ar_user(m_ar_user),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last), .m_r_user(m_r_user),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam int N_SB   = 20;
    localparam int BUDGET = 300;
    logic [127:0] aw_q[$], w_q[$], ar_q[$], b_q[$], r_q[$];
    int aw_got, w_got, ar_got, b_got, r_got;
    int good;

    initial begin
        {s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_lock, s_aw_cache, s_aw_prot} = '0;
        {s_aw_region, s_aw_qos, s_aw_atop, s_aw_user, s_aw_valid} = '0;
        {s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_lock, s_ar_cache, s_ar_prot} = '0;
        {s_ar_region, s_ar_qos, s_ar_user, s_ar_valid} = '0;
        {s_w_data, s_w_strb, s_w_last, s_w_user, s_w_valid} = '0;
        {m_b_id, m_b_resp, m_b_user, m_b_valid} = '0;
        {m_r_id, m_r_data, m_r_resp, m_r_last, m_r_user, m_r_valid} = '0;
        {m_aw_ready, m_w_ready, m_ar_ready, s_b_ready, s_r_ready} = 5'b11111;
        aw_got = 0; w_got = 0; ar_got = 0; b_got = 0; r_got = 0;

        // Power-on reset
        #2 rstn = 1'b0;
        #1;
        check("rst_valids", 128'({m_aw_valid, m_w_valid, m_ar_valid, s_b_valid, s_r_valid}), 128'(0));
        check("rst_readys", 128'({s_aw_ready, s_w_ready, s_ar_ready, m_b_ready, m_r_ready}), 128'(0));
        step(); step();
        rstn = 1'b1;
        #1;
        check("rel_readys_low", 128'({s_aw_ready, s_w_ready, s_ar_ready, m_b_ready, m_r_ready}), 128'(0));
        step();
        check("rel_readys_high", 128'({s_aw_ready, s_w_ready, s_ar_ready, m_b_ready, m_r_ready}), 128'(5'b11111));

        // Single write: AW id=5 addr=0x1000 len=3, four W beats, then B
        s_aw_valid = 1'b1; s_aw_id = 6'd5; s_aw_addr = 32'h1000; s_aw_len = 8'd3;
        s_aw_size = 3'd3; s_aw_burst = 2'd1; s_aw_atop = 6'h2A; s_aw_user = 1'b1; s_aw_qos = 4'h9;
        step();
        s_aw_valid = 1'b0;
        check("wr_aw_valid", 128'(m_aw_valid), 128'(1));
        check("wr_aw_fields", 128'({m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst}),
              128'({6'd5, 32'h1000, 8'd3, 3'd3, 2'd1}));
        check("wr_aw_atop_user_qos", 128'({m_aw_atop, m_aw_user, m_aw_qos}), 128'({6'h2A, 1'b1, 4'h9}));
        for (int i = 0; i < 4; i++) begin
            s_w_valid = 1'b1; s_w_data = 64'hA + 64'(i); s_w_strb = 8'hFF; s_w_last = (i == 3);
            step();
            check("wr_w_beat", 128'({m_w_valid, m_w_last, m_w_strb, m_w_data}),
                  128'({1'b1, (i == 3), 8'hFF, 64'hA + 64'(i)}));
        end
        s_w_valid = 1'b0;
        check("wr_aw_drained", 128'(m_aw_valid), 128'(0));
        step();
        check("wr_w_drained", 128'(m_w_valid), 128'(0));
        m_b_valid = 1'b1; m_b_id = 6'd5; m_b_resp = 2'd0;
        step();
        m_b_valid = 1'b0;
        check("wr_b", 128'({s_b_valid, s_b_id, s_b_resp}), 128'({1'b1, 6'd5, 2'd0}));
        step();
        check("wr_b_drained", 128'(s_b_valid), 128'(0));

        // Mid-sim reset with both AW stages full
        m_aw_ready = 1'b0;
        s_aw_valid = 1'b1; s_aw_addr = 32'h5000;
        step();
        s_aw_addr = 32'h6000;
        step();
        s_aw_valid = 1'b0;
        check("full_aw_rdy", 128'(s_aw_ready), 128'(0));
        check("full_aw_hold", 128'({m_aw_valid, m_aw_addr}), 128'({1'b1, 32'h5000}));
        rstn = 1'b0;
        #1;
        check("midrst_valids", 128'({m_aw_valid, m_w_valid, m_ar_valid, s_b_valid, s_r_valid}), 128'(0));
        check("midrst_readys", 128'({s_aw_ready, s_w_ready, s_ar_ready, m_b_ready, m_r_ready}), 128'(0));
        check("midrst_payload", 128'(m_aw_addr), 128'(0));
        step();
        rstn = 1'b1;
        m_aw_ready = 1'b1;
        step();
        check("midrst_recover_rdy", 128'(s_aw_ready), 128'(1));
        step();
        check("midrst_no_valid", 128'(m_aw_valid), 128'(0));

        // R backpressure: three beats arrive while s_r_ready is low
        s_r_ready = 1'b0;
        m_r_valid = 1'b1; m_r_id = 6'd3; m_r_data = 64'h1111; m_r_last = 1'b0;
        step();
        check("bp_out0", 128'({s_r_valid, s_r_data}), 128'({1'b1, 64'h1111}));
        check("bp_rdy_after1", 128'(m_r_ready), 128'(1));
        m_r_data = 64'h2222;
        step();
        check("bp_rdy_drop", 128'(m_r_ready), 128'(0));
        m_r_data = 64'h3333; m_r_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_stable", 128'({s_r_valid, s_r_id, s_r_data}), 128'({1'b1, 6'd3, 64'h1111}));
            check("bp_rdy_low", 128'(m_r_ready), 128'(0));
        end
        s_r_ready = 1'b1;
        step();
        check("bp_out1", 128'({s_r_valid, s_r_last, s_r_data}), 128'({1'b1, 1'b0, 64'h2222}));
        check("bp_rdy_back", 128'(m_r_ready), 128'(1));
        step();
        m_r_valid = 1'b0;
        check("bp_out2", 128'({s_r_valid, s_r_last, s_r_data}), 128'({1'b1, 1'b1, 64'h3333}));
        step();
        check("bp_empty", 128'(s_r_valid), 128'(0));

        // 256-beat read burst, both sides always ready
        good = 0;
        for (int i = 0; i < 256; i++) begin
            m_r_valid = 1'b1; m_r_data = 64'(i); m_r_last = (i == 255);
            step();
            if (s_r_valid && s_r_data == 64'(i) && s_r_last == (i == 255)) good++;
        end
        m_r_valid = 1'b0;
        check("thr_beats_no_bubble", 128'(good), 128'(256));
        step();
        check("thr_end", 128'(s_r_valid), 128'(0));

        // Concurrent traffic with random ready toggling on every channel
        fork
            begin : aw_prod
                bit hs; int sent;
                hs = 1'b0; sent = 0;
                for (int c = 0; c < BUDGET; c++) begin
                    if (hs) begin sent++; s_aw_valid = 1'b0; end
                    if (!s_aw_valid && sent < N_SB && $urandom_range(0, 3) != 0) begin
                        s_aw_valid = 1'b1; s_aw_addr = 32'h2000 + 32'(sent * 16); s_aw_id = 6'(sent);
                    end
                    hs = s_aw_valid && s_aw_ready;
                    if (hs) aw_q.push_back(128'({s_aw_id, s_aw_addr}));
                    step();
                end
                s_aw_valid = 1'b0;
            end
            begin : aw_cons
                for (int c = 0; c < BUDGET; c++) begin
                    m_aw_ready = 1'($urandom_range(0, 1));
                    if (m_aw_valid && m_aw_ready) begin
                        aw_got++;
                        if (aw_q.size() == 0) check("sb_aw_extra", 128'(1), 128'(0));
                        else check("sb_aw", 128'({m_aw_id, m_aw_addr}), aw_q.pop_front());
                    end
                    step();
                end
            end
            begin : w_prod
                bit hs; int sent;
                hs = 1'b0; sent = 0;
                for (int c = 0; c < BUDGET; c++) begin
                    if (hs) begin sent++; s_w_valid = 1'b0; end
                    if (!s_w_valid && sent < N_SB && $urandom_range(0, 3) != 0) begin
                        s_w_valid = 1'b1; s_w_data = 64'hC000 + 64'(sent); s_w_last = (sent % 4 == 3);
                    end
                    hs = s_w_valid && s_w_ready;
                    if (hs) w_q.push_back(128'({s_w_last, s_w_data}));
                    step();
                end
                s_w_valid = 1'b0;
            end
            begin : w_cons
                for (int c = 0; c < BUDGET; c++) begin
                    m_w_ready = 1'($urandom_range(0, 1));
                    if (m_w_valid && m_w_ready) begin
                        w_got++;
                        if (w_q.size() == 0) check("sb_w_extra", 128'(1), 128'(0));
                        else check("sb_w", 128'({m_w_last, m_w_data}), w_q.pop_front());
                    end
                    step();
                end
            end
            begin : ar_prod
                bit hs; int sent;
                hs = 1'b0; sent = 0;
                for (int c = 0; c < BUDGET; c++) begin
                    if (hs) begin sent++; s_ar_valid = 1'b0; end
                    if (!s_ar_valid && sent < N_SB && $urandom_range(0, 3) != 0) begin
                        s_ar_valid = 1'b1; s_ar_addr = 32'h8000 + 32'(sent * 8); s_ar_id = 6'(sent + 7);
                    end
                    hs = s_ar_valid && s_ar_ready;
                    if (hs) ar_q.push_back(128'({s_ar_id, s_ar_addr}));
                    step();
                end
                s_ar_valid = 1'b0;
            end
            begin : ar_cons
                for (int c = 0; c < BUDGET; c++) begin
                    m_ar_ready = 1'($urandom_range(0, 1));
                    if (m_ar_valid && m_ar_ready) begin
                        ar_got++;
                        if (ar_q.size() == 0) check("sb_ar_extra", 128'(1), 128'(0));
                        else check("sb_ar", 128'({m_ar_id, m_ar_addr}), ar_q.pop_front());
                    end
                    step();
                end
            end
            begin : b_prod
                bit hs; int sent;
                hs = 1'b0; sent = 0;
                for (int c = 0; c < BUDGET; c++) begin
                    if (hs) begin sent++; m_b_valid = 1'b0; end
                    if (!m_b_valid && sent < N_SB && $urandom_range(0, 3) != 0) begin
                        m_b_valid = 1'b1; m_b_id = 6'(sent); m_b_resp = 2'(sent);
                    end
                    hs = m_b_valid && m_b_ready;
                    if (hs) b_q.push_back(128'({m_b_id, m_b_resp}));
                    step();
                end
                m_b_valid = 1'b0;
            end
            begin : b_cons
                for (int c = 0; c < BUDGET; c++) begin
                    s_b_ready = 1'($urandom_range(0, 1));
                    if (s_b_valid && s_b_ready) begin
                        b_got++;
                        if (b_q.size() == 0) check("sb_b_extra", 128'(1), 128'(0));
                        else check("sb_b", 128'({s_b_id, s_b_resp}), b_q.pop_front());
                    end
                    step();
                end
            end
            begin : r_prod
                bit hs; int sent;
                hs = 1'b0; sent = 0;
                for (int c = 0; c < BUDGET; c++) begin
                    if (hs) begin sent++; m_r_valid = 1'b0; end
                    if (!m_r_valid && sent < N_SB && $urandom_range(0, 3) != 0) begin
                        m_r_valid = 1'b1; m_r_data = 64'hD0000 + 64'(sent); m_r_id = 6'(sent + 3);
                        m_r_last = (sent % 5 == 4);
                    end
                    hs = m_r_valid && m_r_ready;
                    if (hs) r_q.push_back(128'({m_r_id, m_r_last, m_r_data}));
                    step();
                end
                m_r_valid = 1'b0;
            end
            begin : r_cons
                for (int c = 0; c < BUDGET; c++) begin
                    s_r_ready = 1'($urandom_range(0, 1));
                    if (s_r_valid && s_r_ready) begin
                        r_got++;
                        if (r_q.size() == 0) check("sb_r_extra", 128'(1), 128'(0));
                        else check("sb_r", 128'({s_r_id, s_r_last, s_r_data}), r_q.pop_front());
                    end
                    step();
                end
            end
        join
        check("sb_aw_count", 128'(aw_got), 128'(N_SB));
        check("sb_w_count",  128'(w_got),  128'(N_SB));
        check("sb_ar_count", 128'(ar_got), 128'(N_SB));
        check("sb_b_count",  128'(b_got),  128'(N_SB));
        check("sb_r_count",  128'(r_got),  128'(N_SB));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
